// File: rtl/lut_bist_pkg.sv
// lut_bist_pkg: shared state encoding, vector-space helper and common expected truth tables.
package lut_bist_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_t;
    localparam logic [1:0] LUT1_BUF = 2'b10;
    localparam logic [1:0] LUT1_INV = 2'b01;
    localparam logic [3:0] LUT2_PASS_I0 = 4'b1010;
    localparam logic [3:0] LUT2_XOR = 4'b0110;
    function automatic int num_vec(input int k);
        return 1 << k;
    endfunction
endpackage

// File: rtl/lut_bist_settle_timer.sv
// lut_bist_settle_timer: loadable down-counter that parks at zero and flags it.
module lut_bist_settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/lut_bist_sequencer.sv
// lut_bist_sequencer: sweeps all inputs of one LUT, compares against INIT, reports pass/first fail/count.
// Define LUT_BIST_STOP_ON_FAIL_EN to end the sweep at the first mismatch and hold that vector on lut_i.
module lut_bist_sequencer
    import lut_bist_pkg::*;
#(
    parameter int N_INPUTS = 2,
    parameter logic [(1<<N_INPUTS)-1:0] INIT = LUT2_PASS_I0,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [N_INPUTS-1:0] lut_i,
    input  logic                lut_o,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS-1:0] fail_vec,
    output logic [CNT_W-1:0]    fail_cnt
);
    localparam int NUM_VEC = num_vec(N_INPUTS);
    localparam int TW = $clog2(SETTLE_CYCLES + 1);
`ifdef LUT_BIST_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif
    state_t state;
    logic [N_INPUTS-1:0] vec;
    logic seen_fail, zero, miss;
    logic [CNT_W-1:0] cnt_inc;
    logic [NUM_VEC-1:0] init_tt;
    assign init_tt = INIT;
    assign miss = lut_o != init_tt[vec];
    assign cnt_inc = &fail_cnt ? fail_cnt : fail_cnt + 1'b1;
    lut_bist_settle_timer #(.W(TW)) u_timer (
        .clk(clk),
        .rst(rst),
        .load(state == DRIVE),
        .load_val(TW'(SETTLE_CYCLES - 1)),
        .zero(zero)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vec <= '0;
            lut_i <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            fail_vec <= '0;
            fail_cnt <= '0;
            seen_fail <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state <= DRIVE;
                    vec <= '0;
                    fail_cnt <= '0;
                    fail_vec <= '0;
                    seen_fail <= 1'b0;
                    busy <= 1'b1;
                    done <= 1'b0;
                    pass <= 1'b0;
                end
                DRIVE: begin
                    lut_i <= vec;
                    state <= SETTLE;
                end
                SETTLE: if (zero) state <= SAMPLE;
                SAMPLE: begin
                    if (miss) begin
                        fail_cnt <= cnt_inc;
                        if (!seen_fail) begin
                            fail_vec <= vec;
                            seen_fail <= 1'b1;
                        end
                    end
                    if (&vec || (STOP_ON_FAIL && miss)) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= !miss && fail_cnt == '0;
                    end else begin
                        vec <= vec + 1'b1;
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_bist_sequencer.sv
// tb_lut_bist_sequencer: directed checks of sweep timing, verdicts, reset and start handling.
module tb_lut_bist_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic lut_o;
    logic [1:0] lut_i, fail_vec;
    logic busy, done, pass;
    logic [7:0] fail_cnt;
    logic [1:0] mode = 2'd0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 0: correct O=I[0], 1: stuck-at-0, 2: inputs swapped (O=I[1])
    always_comb lut_o = mode == 2'd0 ? lut_i[0] : mode == 2'd1 ? 1'b0 : lut_i[1];

    lut_bist_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .lut_i(lut_i), .lut_o(lut_o),
        .busy(busy), .done(done), .pass(pass), .fail_vec(fail_vec), .fail_cnt(fail_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic kick();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".lut_i"}, lut_i, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".done"}, done, 0);
        chk({tag, ".pass"}, pass, 0);
        chk({tag, ".fail_vec"}, fail_vec, 0);
        chk({tag, ".fail_cnt"}, fail_cnt, 0);
    endtask

    // Called right after the start-accept edge; counts edges until done.
    task automatic sweep(input int exp_cycles, input int nvec, input int poke);
        int n = 0;
        chk("busy_after_start", busy, 1);
        while (!done && n < 300) begin
            @(negedge clk) start = (n + 1 == poke);
            @(posedge clk);
            #1 n++;
            if (n % 6 == 1 && n / 6 < nvec) chk("lut_i_step", lut_i, n / 6);
        end
        start = 1'b0;
        chk("sweep_cycles", n, exp_cycles);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic chk_result(input logic p, input int cnt, input int fv);
        chk("pass", pass, p);
        chk("fail_cnt", fail_cnt, cnt);
        chk("fail_vec", fail_vec, fv);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        rst = 1'b0;
        mode = 2'd0;
        kick();
        sweep(24, 4, 0);
        chk_result(1'b1, 0, 0);
        chk("lut_i_hold", lut_i, 3);
        mode = 2'd1;
        kick();
        chk("restart_cnt_clear", fail_cnt, 0);
        chk("restart_done_low", done, 0);
`ifdef LUT_BIST_STOP_ON_FAIL_EN
        sweep(12, 2, 0);
        chk_result(1'b0, 1, 1);
        chk("lut_i_probe", lut_i, 1);
`else
        sweep(24, 4, 0);
        chk_result(1'b0, 2, 1);
`endif
        mode = 2'd2;
        kick();
`ifdef LUT_BIST_STOP_ON_FAIL_EN
        sweep(12, 2, 0);
        chk_result(1'b0, 1, 1);
`else
        sweep(24, 4, 0);
        chk_result(1'b0, 2, 1);
`endif
        mode = 2'd0;
        kick();
        repeat (15) @(posedge clk);
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(posedge clk);
        #1 chk_reset("mid_rst");
        rst = 1'b0;
        start = 1'b0;
        kick();
        sweep(24, 4, 0);
        chk_result(1'b1, 0, 0);
        kick();
        sweep(24, 4, 8);
        chk_result(1'b1, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lut_bist_sequencer.md
Name: lut_bist_sequencer

Overview:
- On-fabric self-test engine for a single K-input LUT under test.
- Sweeps every input combination onto the LUT inputs and waits a programmable settle interval.
- Samples the LUT output and compares it against the expected truth table; reports pass/fail, the first failing vector and a failure count.
- Sits beside a placed LUT in pp3 feature/install tests so the check runs in hardware, not only in timing simulation.

Parameters:
- N_INPUTS, 2, LUT input count K (1..6); vector space is 2^K.
- INIT, 4'b1010, expected truth table, width 2^N_INPUTS; bit v is the expected output for input vector v. Default is O = I[0].
- SETTLE_CYCLES, 4, clocks between driving a vector and sampling (>=1).
- CNT_W, 8, width of the failure counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- lut_i  out  N_INPUTS  drive to the LUT inputs under test
- lut_o  in  1  LUT output being checked
- busy  out  1  high from the cycle after an accepted start until done asserts
- done  out  1  high while in DONE state
- pass  out  1  valid when done=1; 1 if all vectors matched
- fail_vec  out  N_INPUTS  first mismatching vector; 0 if none
- fail_cnt  out  CNT_W  number of mismatching vectors; saturates at all-ones

Behaviour:
- Reset values: lut_i=0, busy=0, done=0, pass=0, fail_vec=0, fail_cnt=0; state=IDLE.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> DRIVE.
  - Clear vec=0, fail_cnt=0, fail_vec=0, first-fail flag.
  - start while not IDLE/DONE is ignored.
- DRIVE (1 cycle): lut_i<=vec; load the settle counter with SETTLE_CYCLES-1 -> SETTLE.
- SETTLE: decrement; at 0 -> SAMPLE. Total of SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (1 cycle):
  - Compare lut_o with INIT[vec].
  - On mismatch: fail_cnt increments (saturating). If it is the first mismatch, latch fail_vec<=vec and set the first-fail flag.
  - If vec == 2^N_INPUTS-1 -> DONE; otherwise vec<=vec+1 -> DRIVE.
- Per-vector period: SETTLE_CYCLES+2 clocks. Full sweep: 2^N_INPUTS*(SETTLE_CYCLES+2) clocks from the first DRIVE cycle.
- DONE:
  - done=1, busy=0, pass=(fail_cnt==0).
  - lut_i holds the last vector.
  - start=1 -> restart the sweep (as from IDLE); this is the only exit besides rst.
- vec counter is N_INPUTS+0 bits. Wrap is never used; termination is by the all-ones compare.
- rst mid-sweep: all state and outputs return to reset values on the next edge; no partial results are retained.
- start and rst in the same cycle: rst wins.
- lut_o is sampled only in SAMPLE; it is ignored in all other states.

Optional Feature:
- Macro: LUT_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in SAMPLE goes directly to DONE with fail_cnt=1, fail_vec=vec and pass=0. Remaining vectors are not applied and lut_i holds the failing vector for probing.
- Undefined: the full sweep always completes and fail_cnt counts all mismatches.

Decomposition:
- Shared package lut_bist_pkg holds:
  - state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE);
  - localparam helper NUM_VEC = 1<<N_INPUTS;
  - default INIT constants for common test LUTs (lut1 buffer/inverter, lut2 pass-I0, lut2 xor).
- One natural sub-module: lut_bist_settle_timer. It is a loadable down-counter with a zero flag, reusable for the pacing of other fabric self-tests.

Test Plan:
- Reset, then a correct LUT model O=I[0] with INIT=4'b1010, SETTLE_CYCLES=4: pulse start -> lut_i steps 0,1,2,3 at 6-clock spacing. done rises 24 clocks after the first DRIVE with pass=1, fail_cnt=0, fail_vec=0.
- LUT model stuck-at-0, same INIT -> done with pass=0, fail_cnt=2, fail_vec=2'b01.
- LUT model O=I[1] (swapped inputs) -> pass=0, fail_cnt=2, fail_vec=2'b01.
- Assert rst during SETTLE of vector 2, then pulse start -> outputs return to reset values on the next edge. The new sweep starts from vector 0 and completes with pass=1.
- Pulse start while busy (vector 1) -> ignored; sweep timing unchanged. start while in DONE -> fresh sweep with counters cleared.
- With LUT_BIST_STOP_ON_FAIL_EN and a stuck-at-0 model -> done after vector 1's SAMPLE (12 clocks), fail_cnt=1, fail_vec=1, lut_i held at 2'b01.
